wb_dmem_ctrl: RTL
=================

# wb_dmem_ctrl

Parametrised Wishbone B4 classic-cycle data memory slave, the successor to the fixed 512-word data memory in the SoC core. It adds a configurable depth and base address, a registered one-wait-state acknowledge, address-range error termination and optional per-byte parity. It sits on the core data bus behind the interconnect decoder and serves load/store traffic from the CPU.

## Interface
- DEPTH, 1024: number of 32-bit words; power of two, 16..65536; AW = $clog2(DEPTH).
- BASE_ADDR, 32'h0000_0000: byte base address; must be aligned to DEPTH*4.
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low; memory array is not cleared.
- cyc_i  in  1  bus cycle.
- stb_i  in  1  strobe.
- adr_i  in  32  byte address; bits [1:0] ignored.
- we_i  in  1  1 = write, 0 = read.
- sel_i  in  4  byte lane enables; bit n covers dat_i[8n+7:8n].
- dat_i  in  32  write data.
- par_inj_i  in  1  parity fault injection; flips stored parity of lane 0 on writes. Only used with DMEM_PARITY_EN; otherwise ignored, tie 0.
- dat_o  out  32  read data, registered.
- ack_o  out  1  normal termination, registered.
- err_o  out  1  error termination, registered.

## Operation
- Request: req = cyc_i & stb_i, sampled only in state IDLE.
- Hit: hit = (adr_i[31:AW+2] == BASE_ADDR[31:AW+2]). word index = adr_i[AW+1:2].
- FSM, two states:
  - IDLE to RESP on req; otherwise stay in IDLE.
  - RESP to IDLE unconditionally.
- At the IDLE to RESP edge:
  - Hit write: each lane with sel_i[n]=1 is written; other lanes are unchanged.
  - Hit read: dat_o <= mem[index], full word regardless of sel_i.
  - Set ack_o=1 for any hit, err_o=1 for any miss.
  - Miss: no write, dat_o <= 0.
- In RESP: exactly one of ack_o/err_o is high. Both clear on the RESP to IDLE edge.
- Write data: dat_o on a hit write is don't-care; the implementation drives 0.
- sel_i=0 write: acknowledged, memory unchanged.
- Master drops cyc_i/stb_i while in RESP: the response still completes, no side effect, FSM returns to IDLE.
- stb_i held high after ack: the next access is sampled in the following IDLE cycle. Throughput is 1 access per 2 cycles.
- Back-to-back write then read of the same word: the read returns the new data. The write has committed before the read is sampled.

## Timing
- Reset values, asynchronous on rst_ni=0: state=IDLE, ack_o=0, err_o=0, dat_o=0.
- Reset mid-RESP aborts the response. A write already committed on the prior edge remains in memory.
- Latency: request sampled at edge N; ack_o/err_o and dat_o are valid from edge N+1 to edge N+2.
- Memory inference: single-port synchronous write with byte enables; read captured into the dat_o register. Either LUTRAM or block RAM is legal.
- No combinational path from any input to any output.

## Configuration
- DMEM_PARITY_EN defined:
  - Each byte lane stores an extra even-parity bit, written with its lane. Lane 0 parity is inverted when par_inj_i=1.
  - On a hit read, any lane parity mismatch gives err_o=1 and ack_o=0. dat_o still carries the raw word.
  - Hit write behaviour is unchanged.
- DMEM_PARITY_EN undefined: no parity storage, par_inj_i is unused, and hit reads always give ack_o.

## Test plan
Bench configuration: DEPTH=512, BASE_ADDR=32'h0000_2000.
- Reset: hold rst_ni=0 for 3 cycles, release -> ack_o=0, err_o=0, dat_o=0, and a request is accepted on the first edge after release.
- Full write then read: write 32'hDEADBEEF to 32'h2010 with sel=4'hF, then read 32'h2010 -> ack_o a single cycle each time; read dat_o=32'hDEADBEEF one cycle after the sample edge.
- Byte lanes: after the above, write 32'h11223344 to 32'h2010 with sel=4'b0101, then read -> 32'hDE22BE44.
- Out of range: read 32'h2800 and write 32'h1FFC -> err_o=1 and ack_o=0 on each; dat_o=0; the word at 32'h27FC is unchanged.
- Wrap and abort: write then read 32'h27FC (last word) -> correct data returned; drop stb_i in RESP -> single ack pulse, FSM back in IDLE; stb_i held high -> ack every second cycle.
- Parity (DMEM_PARITY_EN only): write 32'hA5A5A5A5 to 32'h2000 with par_inj_i=1, then read -> err_o=1, dat_o=32'hA5A5A5A5; rewrite with par_inj_i=0, then read -> ack_o=1.

Source files
------------

// File: rtl/wb_dmem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_dmem_ctrl_if
// Description : Wishbone B4 classic data-bus bundle for wb_dmem_ctrl.
//               Signal names follow the slave's point of view.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_dmem_ctrl_if;
  logic        cyc_i;
  logic        stb_i;
  logic [31:0] adr_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_i;
  logic        par_inj_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        err_o;

  modport master (
    output cyc_i, stb_i, adr_i, we_i, sel_i, dat_i, par_inj_i,
    input  dat_o, ack_o, err_o
  );

  modport slave (
    input  cyc_i, stb_i, adr_i, we_i, sel_i, dat_i, par_inj_i,
    output dat_o, ack_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wb_dmem_ctrl
// Description : Wishbone B4 classic data memory slave, one registered wait
//               state, address-range error, optional per-byte parity
//               (enabled by defining DMEM_PARITY_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_dmem_ctrl #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  wire logic      clk_i,
  input  wire logic      rst_ni,
  wb_dmem_ctrl_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          w_req;
  logic          w_hit;
  logic [AW-1:0] w_idx;
  logic          w_wr_en;
  logic [31:0]   w_rdata;
  logic [3:0]    w_par_bad;

  logic          w_ack_nxt;
  logic          w_err_nxt;
  logic [31:0]   w_dat_nxt;

  logic          r_ack;
  logic          r_err;
  logic [31:0]   r_dat;

  logic          w_unused;

  assign w_req = bus.cyc_i & bus.stb_i;
  assign w_hit = (bus.adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign w_idx = bus.adr_i[AW+1:2];

  // Only the IDLE state samples the bus, so a held strobe yields one access
  // every other cycle and anything seen during RESP is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_dat_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt = S_RESP;
          if (!w_hit) begin
            w_err_nxt = 1'b1;
          end else if (bus.we_i) begin
            w_wr_en   = 1'b1;
            w_ack_nxt = 1'b1;
          end else begin
            w_dat_nxt = w_rdata;
            w_err_nxt = |w_par_bad;
            w_ack_nxt = ~(|w_par_bad);
          end
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_dat   <= w_dat_nxt;
    end
  end

  // One array per byte lane gives a plain byte-enable write per lane.
  for (genvar n = 0; n < 4; n++) begin : g_lane
    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
      if (w_wr_en && bus.sel_i[n]) begin
        r_mem[w_idx] <= bus.dat_i[8*n +: 8];
      end
    end

    assign w_rdata[8*n +: 8] = r_mem[w_idx];

`ifdef DMEM_PARITY_EN
    logic r_par [DEPTH];
    logic w_par_wr;

    if (n == 0) begin : g_inj
      assign w_par_wr = (^bus.dat_i[7:0]) ^ bus.par_inj_i;
    end else begin : g_noinj
      assign w_par_wr = ^bus.dat_i[8*n +: 8];
    end

    always_ff @(posedge clk_i) begin
      if (w_wr_en && bus.sel_i[n]) begin
        r_par[w_idx] <= w_par_wr;
      end
    end

    assign w_par_bad[n] = (^r_mem[w_idx]) ^ r_par[w_idx];
`else
    assign w_par_bad[n] = 1'b0;
`endif
  end

`ifdef DMEM_PARITY_EN
  assign w_unused = ^bus.adr_i[1:0];
`else
  assign w_unused = ^{bus.adr_i[1:0], bus.par_inj_i};
`endif

  assign bus.ack_o = r_ack;
  assign bus.err_o = r_err;
  assign bus.dat_o = r_dat;

endmodule
`default_nettype wire
